// File: rtl/pc_gen.sv
// Program-counter generator: PC register with reset/exception vectors, next-PC
// selection for SEQ/BR/J/JR/JAL/RET, and a circular return-address stack.
module pc_gen #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_PC    = 32'h0000_4180,
    parameter int          RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  op,
    input  logic        br_taken,
    input  logic [25:0] imm26,
    input  logic [31:0] reg32,
    input  logic        stall,
    input  logic        exc_req,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] npc,
    output logic        ras_empty,
    output logic        ras_full,
    output logic        ras_mispred
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    typedef enum logic [2:0] {
        OP_SEQ = 3'b000,
        OP_BR  = 3'b001,
        OP_J   = 3'b010,
        OP_JR  = 3'b011,
        OP_JAL = 3'b100,
        OP_RET = 3'b101
    } op_e;

    logic [31:0]      pc_reg;
    logic [PTR_W-1:0] tp_reg, tp_next, wr_ptr;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             mispred_reg, mispred_next;
    logic [31:0]      ras_mem [RAS_DEPTH];
    logic [31:0]      br_off, op_target, ras_top;
    logic             update_en, push_en, pop_en;

    assign pc        = pc_reg;
    assign pc_plus4  = pc_reg + 32'd4;
    assign ras_empty = (cnt_reg == '0);
    assign ras_full  = (cnt_reg == CNT_MAX);
    assign ras_mispred = mispred_reg;

    assign br_off    = {{14{imm26[15]}}, imm26[15:0], 2'b00};
    assign update_en = !exc_req && !stall;
    assign push_en   = update_en && (op == OP_JAL);
    assign pop_en    = update_en && (op == OP_RET);
    assign wr_ptr    = tp_reg + PTR_W'(1);
    assign ras_top   = ras_mem[tp_reg];

    always_comb begin
        op_target = pc_plus4;
        case (op)
            OP_BR:         op_target = br_taken ? (pc_plus4 + br_off) : pc_plus4;
            OP_J, OP_JAL:  op_target = {pc_reg[31:28], imm26, 2'b00};
            // RET always follows the register value; the RAS only grades it
            OP_JR, OP_RET: op_target = reg32;
            default:       op_target = pc_plus4;
        endcase
    end

    always_comb begin
        npc = op_target;
        if (exc_req) begin
            npc = EXC_PC;
        end else if (stall) begin
            npc = pc_reg;
        end
    end

    always_comb begin
        tp_next      = tp_reg;
        cnt_next     = cnt_reg;
        mispred_next = 1'b0;
        if (push_en) begin
            tp_next = wr_ptr;
            // when full the write lands on the oldest entry and count saturates
            if (cnt_reg != CNT_MAX) begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end else if (pop_en) begin
            if (cnt_reg == '0) begin
                mispred_next = 1'b1;
            end else begin
                mispred_next = (ras_top != reg32);
                tp_next      = tp_reg - PTR_W'(1);
                cnt_next     = cnt_reg - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_reg      <= RESET_PC;
            tp_reg      <= '0;
            cnt_reg     <= '0;
            mispred_reg <= 1'b0;
        end else begin
            pc_reg      <= npc;
            tp_reg      <= tp_next;
            cnt_reg     <= cnt_next;
            mispred_reg <= mispred_next;
        end
    end

    // Storage is never cleared; entries are unreachable while the count is zero
    always_ff @(posedge clk) begin
        if (push_en && reset_n) begin
            ras_mem[wr_ptr] <= pc_plus4;
        end
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the single-cycle/pipelined MIPS datapath; successor to the combinational next-PC unit. It holds the PC register with a configurable reset vector, computes the next PC for sequential, branch, jump, jump-and-link and register-jump flows, and supports stall and exception redirect. A circular return-address stack (RAS) of configurable depth tracks `jal` return addresses and flags return mispredictions for the performance counters.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value loaded on reset.
- `EXC_PC`, default 32'h0000_4180: PC loaded on exception request.
- `RAS_DEPTH`, default 4: number of RAS entries; must be a power of two, 2..16.
- `clk` input, 1 bit: the single clock; all state changes on its rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `op` input, 3 bits: next-PC mode.
  - 000 SEQ
  - 001 BR
  - 010 J
  - 011 JR
  - 100 JAL
  - 101 RET
  - 110/111 treated as SEQ.
- `br_taken` input, 1 bit: branch condition; used only when `op`=BR.
- `imm26` input, 26 bits: instruction index field; [15:0] is the branch offset.
- `reg32` input, 32 bits: register-jump target (rs value).
- `stall` input, 1 bit: hold PC and RAS.
- `exc_req` input, 1 bit: redirect to `EXC_PC`.
- `pc` output, 32 bits: current PC (registered).
- `pc_plus4` output, 32 bits: `pc`+4, combinational.
- `npc` output, 32 bits: value `pc` takes at the next edge, combinational.
- `ras_empty` output, 1 bit: RAS holds no entries.
- `ras_full` output, 1 bit: RAS holds `RAS_DEPTH` entries.
- `ras_mispred` output, 1 bit: registered one-cycle pulse on a mispredicted RET.

## Operation
- Offset: `off` = sign-extended `imm26[15:0]`, shifted left by 2, 32-bit.
- Target by `op`; all arithmetic is mod 2^32 and wraps silently:
  - SEQ: `pc_plus4`.
  - BR: `pc_plus4`+`off` if `br_taken`, else `pc_plus4`.
  - J and JAL: {`pc`[31:28], `imm26`, 2'b00}.
  - JR and RET: `reg32`. RET never uses the RAS value as its target.
- Priority when computing `npc`:
  - `exc_req` gives `EXC_PC`.
  - Otherwise `stall` gives `pc`.
  - Otherwise the op target.
- RAS state: storage array, top pointer `tp`, occupancy count `cnt` (0..`RAS_DEPTH`).
- RAS push (JAL, not stalled, no `exc_req`):
  - Write `pc_plus4` at `tp`+1 and set `tp`=`tp`+1, both mod `RAS_DEPTH`.
  - `cnt` saturates at `RAS_DEPTH`; when full, the oldest entry is overwritten.
- RAS pop (RET, not stalled, no `exc_req`):
  - If `cnt`>0: compare the entry at `tp` with `reg32`, then `tp`=`tp`-1 and `cnt`=`cnt`-1.
  - If `cnt`=0: no pointer change, and the pop counts as mispredicted.
- `ras_mispred` goes high the cycle after a pop that was empty, or whose top entry differed from `reg32`; otherwise it is 0.
- Stall or `exc_req` suppresses all RAS updates and forces `ras_mispred` low next cycle.
- `ras_empty` is (`cnt`==0) and `ras_full` is (`cnt`==`RAS_DEPTH`); both are derived from registered state.

## Timing
- Asynchronous assertion of `reset_n`=0 forces, immediately and for as long as it is held:
  - `pc`=`RESET_PC`, `cnt`=0, `tp`=0, `ras_mispred`=0.
  - As a result `ras_empty`=1, `ras_full`=0, `pc_plus4`=`RESET_PC`+4.
- RAS contents are not cleared on reset; they are unreachable while `cnt`=0.
- Reset release is sampled at the rising edge; the first update occurs at the first edge after `reset_n` rises.
- `pc` gets `npc` at every rising edge while not in reset: one-cycle latency from `op` to `pc`.
- `npc` and `pc_plus4` are purely combinational from `pc` and the inputs, settling within the same cycle.
- A RAS push or pop takes effect at the same edge as the PC update. A RET one cycle after a JAL sees the pushed entry.
- Reset asserted mid-stall or mid-exception: reset wins; the stalled or exception state is discarded.
- `exc_req` together with `stall`: the exception wins and the PC updates.

## Test plan
- Reset and sequential flow:
  - Hold `reset_n`=0 → `pc`=0x3000, `ras_empty`=1.
  - Release, `op`=SEQ for 3 cycles → `pc` 0x3004, 0x3008, 0x300C.
- Branch:
  - `pc`=0x3010, BR, `imm26[15:0]`=0xFFFE, `br_taken`=1 → `pc`=0x300C.
  - Same with `br_taken`=0 → `pc`=0x3014.
  - `imm26[15:0]`=0x0003 with `br_taken`=1 → `pc`=0x3020.
- Jumps:
  - `pc`=0x3000, J, `imm26`=0x0000C40 → `pc`=0x3100.
  - JR with `reg32`=0x0000_3F00 → `pc`=0x3F00.
- RAS correct return:
  - JAL at 0x3000 (push 0x3004), then RET with `reg32`=0x3004 → `pc`=0x3004.
  - `ras_mispred` stays 0 and `ras_empty`=1 afterwards.
- RAS overflow and mispredict (depth 4):
  - 5 JALs from PCs 0x3000, 0x3100, … → `ras_full`=1.
  - 4 RETs with matching `reg32` → no `ras_mispred`.
  - 5th RET → `ras_mispred`=1 for one cycle; `pc`=`reg32`.
  - RET with `reg32` ≠ top → `ras_mispred` pulse.
- Stall, exception and asynchronous reset:
  - `stall`=1 for 2 cycles with `op`=JAL → `pc` held, `cnt` unchanged.
  - `exc_req`=1 with `stall`=1 → `pc`=0x4180.
  - Drop `reset_n` mid-cycle → `pc`=0x3000 before the next edge.
